// File: rtl/alu_out_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_out_fifo_if
// Bundles the producer side (ALU results + flags), the consumer side (head
// entry + flags), and the status/control signals of the ALU output FIFO.
//   slave  : view taken by the FIFO itself
//   master : view taken by whatever drives the FIFO (datapath + consumer)
// Signals:
//   flush, sticky_clr                       control into the FIFO
//   in_valid/in_ready, result_in, *_in      producer handshake + payload
//   out_valid/out_ready, result_out, *_out  consumer handshake + head entry
//   count, sticky_cout, sticky_ovf, drop_err status out of the FIFO
// ---------------------------------------------------------------------------
interface alu_out_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             sticky_clr;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result_in;
  logic             cout_in;
  logic             negative_in;
  logic             zero_in;
  logic             overflow_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_out;
  logic             cout_out;
  logic             negative_out;
  logic             zero_out;
  logic             overflow_out;

  logic [CW-1:0]    count;
  logic             sticky_cout;
  logic             sticky_ovf;
  logic             drop_err;

  modport slave (
    input  flush, sticky_clr,
    input  in_valid, result_in, cout_in, negative_in, zero_in, overflow_in,
    output in_ready,
    input  out_ready,
    output out_valid, result_out, cout_out, negative_out, zero_out, overflow_out,
    output count, sticky_cout, sticky_ovf, drop_err
  );

  modport master (
    output flush, sticky_clr,
    output in_valid, result_in, cout_in, negative_in, zero_in, overflow_in,
    input  in_ready,
    output out_ready,
    input  out_valid, result_out, cout_out, negative_out, zero_out, overflow_out,
    input  count, sticky_cout, sticky_ovf, drop_err
  );
endinterface

// File: rtl/alu_out_fifo.sv
// ---------------------------------------------------------------------------
// alu_out_fifo
// First-word-fall-through FIFO buffering ALU results together with their
// cout/negative/zero/overflow flags, with valid/ready on both sides.
// Also keeps sticky cout/overflow flags over accepted entries and flags
// inputs that arrive while the FIFO is full.
// Ports:
//   clk    in  clock; every register updates on the falling edge
//   reset  in  asynchronous, active-high
//   bus    slave view of alu_out_fifo_if (handshakes, payload, status)
// Parameters:
//   WIDTH  result width in bits
//   DEPTH  number of entries; power of two, >= 2
// ---------------------------------------------------------------------------
module alu_out_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_out_fifo_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + 4;

  // Entry layout: {cout, negative, zero, overflow, result}
  localparam int COUT_B = WIDTH + 3;
  localparam int NEG_B  = WIDTH + 2;
  localparam int ZERO_B = WIDTH + 1;
  localparam int OVF_B  = WIDTH;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          sticky_cout_q, sticky_cout_d;
  logic          sticky_ovf_q,  sticky_ovf_d;
  logic          drop_err_q,    drop_err_d;

  // -------------------------------------------------------------------------
  // Status and handshake qualification
  // -------------------------------------------------------------------------
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready depends only on registered occupancy, so a full FIFO stays
  // not-ready even when the consumer is popping on the same edge.
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  // flush discards any simultaneous push, so it must also gate the write.
  assign wr_en = push && !bus.flush;

  assign wr_entry = {bus.cout_in, bus.negative_in, bus.zero_in,
                     bus.overflow_in, bus.result_in};

  // -------------------------------------------------------------------------
  // Storage: not reset; contents are only meaningful between the pointers.
  // -------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head is read asynchronously so a freshly pushed entry is visible right
  // after the edge that wrote it (fall-through).
  assign head_entry = mem_q[rd_ptr_q];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    sticky_cout_d = sticky_cout_q;
    sticky_ovf_d  = sticky_ovf_q;
    drop_err_d    = 1'b0;

    if (bus.flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      sticky_cout_d = 1'b0;
      sticky_ovf_d  = 1'b0;
    end else begin
      // DEPTH is a power of two, so natural AW-bit rollover is the modulo wrap.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // Clear happens before set so a push alongside sticky_clr leaves
      // exactly the pushed entry's flags.
      if (bus.sticky_clr) begin
        sticky_cout_d = 1'b0;
        sticky_ovf_d  = 1'b0;
      end
      if (push) begin
        sticky_cout_d = sticky_cout_d | bus.cout_in;
        sticky_ovf_d  = sticky_ovf_d  | bus.overflow_in;
      end

      drop_err_d = bus.in_valid && full;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sticky_cout_q <= 1'b0;
      sticky_ovf_q  <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sticky_cout_q <= sticky_cout_d;
      sticky_ovf_q  <= sticky_ovf_d;
      drop_err_q    <= drop_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs; payload is forced to zero while empty so stale storage never
  // leaks to the consumer.
  // -------------------------------------------------------------------------
  assign bus.in_ready     = !full;
  assign bus.out_valid    = !empty;
  assign bus.result_out   = empty ? '0   : head_entry[WIDTH-1:0];
  assign bus.cout_out     = empty ? 1'b0 : head_entry[COUT_B];
  assign bus.negative_out = empty ? 1'b0 : head_entry[NEG_B];
  assign bus.zero_out     = empty ? 1'b0 : head_entry[ZERO_B];
  assign bus.overflow_out = empty ? 1'b0 : head_entry[OVF_B];
  assign bus.count        = count_q;
  assign bus.sticky_cout  = sticky_cout_q;
  assign bus.sticky_ovf   = sticky_ovf_q;
  assign bus.drop_err     = drop_err_q;

endmodule
